// File: rtl/guess_entry.sv
// guess_entry: working-guess editor, edit cursor, submitted-guess history bank and scorer handshake.
// Build option: define GUESS_CLEAR_EN to reset the working guess and cursor on every accepted transfer.

module guess_entry #(
    parameter int NUM_COLORS = 6,
    parameter int HIST_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_submit,
    input  logic        hist_mode,
    input  logic        submit_ready,
    output logic        submit_valid,
    output logic [11:0] submit_guess,
    output logic [2:0]  guess_rgb0,
    output logic [2:0]  guess_rgb1,
    output logic [2:0]  guess_rgb2,
    output logic [2:0]  guess_rgb3,
    output logic [2:0]  history_rgb0,
    output logic [2:0]  history_rgb1,
    output logic [2:0]  history_rgb2,
    output logic [2:0]  history_rgb3,
    output logic        blink_enable,
    output logic [1:0]  blink_led,
    output logic [4:0]  hist_count,
    output logic        hist_full
);

    // state  | meaning
    // EDIT   | player edits the working guess, cursor blinks
    // SUBMIT | guess offered to the scorer, all buttons ignored
    // BROWSE | history shows the entry at the read pointer

    localparam int         PW        = $clog2(HIST_DEPTH);
    localparam logic [2:0] MAX_COLOR = 3'(NUM_COLORS);
    localparam logic [4:0] DEPTH_CNT = 5'(HIST_DEPTH);

    typedef enum logic [1:0] {
        EDIT   = 2'd0,
        SUBMIT = 2'd1,
        BROWSE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     guess_q [4];
    logic [2:0]     guess_d [4];
    logic [1:0]     cursor_q, cursor_d;
    logic [11:0]    submit_guess_q, submit_guess_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]     hist_count_q, hist_count_d;
    logic [11:0]    history_q, history_d;
    logic [11:0]    bank_q [HIST_DEPTH];
    logic           bank_we;
    logic           full;
    logic [PW-1:0]  newest_ptr;
    logic [PW-1:0]  oldest_ptr;

    assign full       = (hist_count_q == DEPTH_CNT);
    assign newest_ptr = wr_ptr_q - PW'(1);
    // Once full the write pointer has wrapped, so this still lands on the oldest slot.
    assign oldest_ptr = wr_ptr_q - hist_count_q[PW-1:0];

    always_comb begin
        state_d        = state_q;
        guess_d        = guess_q;
        cursor_d       = cursor_q;
        submit_guess_d = submit_guess_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        hist_count_d   = hist_count_q;
        bank_we        = 1'b0;

        case (state_q)
            EDIT: begin
                if (btn_submit && !full) begin
                    state_d        = SUBMIT;
                    submit_guess_d = {guess_q[3], guess_q[2], guess_q[1], guess_q[0]};
                end else if (hist_mode && (hist_count_q != 5'd0)) begin
                    state_d  = BROWSE;
                    rd_ptr_d = newest_ptr;
                end else if (btn_up) begin
                    guess_d[cursor_q] = (guess_q[cursor_q] >= MAX_COLOR) ? 3'd1
                                                                         : guess_q[cursor_q] + 3'd1;
                end else if (btn_down) begin
                    guess_d[cursor_q] = (guess_q[cursor_q] <= 3'd1) ? MAX_COLOR
                                                                    : guess_q[cursor_q] - 3'd1;
                end else if (btn_left) begin
                    cursor_d = cursor_q - 2'd1;
                end else if (btn_right) begin
                    cursor_d = cursor_q + 2'd1;
                end
            end
            SUBMIT: begin
                if (submit_ready) begin
                    state_d      = EDIT;
                    bank_we      = 1'b1;
                    wr_ptr_d     = wr_ptr_q + PW'(1);
                    hist_count_d = hist_count_q + 5'd1;
`ifdef GUESS_CLEAR_EN
                    for (int i = 0; i < 4; i++) begin
                        guess_d[i] = 3'd1;
                    end
                    cursor_d = 2'd0;
`else
                    cursor_d = cursor_q;
`endif
                end
            end
            BROWSE: begin
                if (!hist_mode) begin
                    state_d = EDIT;
                end else if (btn_up) begin
                    if (rd_ptr_q != oldest_ptr) begin
                        rd_ptr_d = rd_ptr_q - PW'(1);
                    end
                end else if (btn_down) begin
                    if (rd_ptr_q != newest_ptr) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = EDIT;
            end
        endcase
    end

    always_comb begin
        history_d = 12'd0;
        if (state_q == BROWSE) begin
            history_d = bank_q[rd_ptr_q];
        end else if (hist_count_q != 5'd0) begin
            history_d = bank_q[newest_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= EDIT;
            for (int i = 0; i < 4; i++) begin
                guess_q[i] <= 3'd1;
            end
            cursor_q       <= 2'd0;
            submit_guess_q <= 12'd0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            hist_count_q   <= 5'd0;
            history_q      <= 12'd0;
        end else begin
            state_q        <= state_d;
            guess_q        <= guess_d;
            cursor_q       <= cursor_d;
            submit_guess_q <= submit_guess_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            hist_count_q   <= hist_count_d;
            history_q      <= history_d;
        end
    end

    // Bank has no reset; a transfer coinciding with reset must not land.
    always_ff @(posedge clk) begin
        if (bank_we && !rst) begin
            bank_q[wr_ptr_q] <= submit_guess_q;
        end
    end

    assign submit_valid = (state_q == SUBMIT);
    assign submit_guess = submit_guess_q;
    assign guess_rgb0   = guess_q[0];
    assign guess_rgb1   = guess_q[1];
    assign guess_rgb2   = guess_q[2];
    assign guess_rgb3   = guess_q[3];
    assign history_rgb0 = history_q[2:0];
    assign history_rgb1 = history_q[5:3];
    assign history_rgb2 = history_q[8:6];
    assign history_rgb3 = history_q[11:9];
    assign blink_enable = (state_q == EDIT);
    assign blink_led    = cursor_q;
    assign hist_count   = hist_count_q;
    assign hist_full    = full;

endmodule

// File: tb/tb_guess_entry.sv
// Self-checking bench for guess_entry: table-driven edit vectors, submit scoreboard and history browse.
// Expectations follow the GUESS_CLEAR_EN build option when it is defined.

module tb_guess_entry;

    localparam int NC = 6;
    localparam int HD = 8;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_SUB   = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_submit = 1'b0;
    logic        hist_mode = 1'b0;
    logic        submit_ready = 1'b0;
    logic        submit_valid;
    logic [11:0] submit_guess;
    logic [2:0]  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
    logic [2:0]  history_rgb0, history_rgb1, history_rgb2, history_rgb3;
    logic        blink_enable;
    logic [1:0]  blink_led;
    logic [4:0]  hist_count;
    logic        hist_full;

    guess_entry #(.NUM_COLORS(NC), .HIST_DEPTH(HD)) dut (
        .clk(clk), .rst(rst),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .btn_submit(btn_submit), .hist_mode(hist_mode), .submit_ready(submit_ready),
        .submit_valid(submit_valid), .submit_guess(submit_guess),
        .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1), .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
        .history_rgb0(history_rgb0), .history_rgb1(history_rgb1),
        .history_rgb2(history_rgb2), .history_rgb3(history_rgb3),
        .blink_enable(blink_enable), .blink_led(blink_led),
        .hist_count(hist_count), .hist_full(hist_full)
    );

    always #5 clk = ~clk;

    wire [11:0] guess_vec = {guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0};
    wire [11:0] hist_vec  = {history_rgb3, history_rgb2, history_rgb1, history_rgb0};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] sb_q [$];
    logic [11:0] m_hist [$];
    int          m_g [4];
    int          m_cur;

    typedef struct {
        logic [4:0]  btn;
        logic [11:0] exp_g;
        int          exp_c;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pk(input int g3, input int g2, input int g1, input int g0);
        return {3'(g3), 3'(g2), 3'(g1), 3'(g0)};
    endfunction

    function automatic logic [11:0] m_pk();
        return pk(m_g[3], m_g[2], m_g[1], m_g[0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        {btn_submit, btn_up, btn_down, btn_left, btn_right} = b;
        tick();
        {btn_submit, btn_up, btn_down, btn_left, btn_right} = B_NONE;
    endtask

    task automatic after_xfer();
`ifdef GUESS_CLEAR_EN
        for (int i = 0; i < 4; i++) m_g[i] = 1;
        m_cur = 0;
`endif
    endtask

    task automatic set_guess(input int t0, input int t1, input int t2, input int t3);
        int t[4];
        t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 4 && m_cur != p; n++) begin
                press(B_RIGHT);
                m_cur = (m_cur + 1) % 4;
            end
            for (int n = 0; n < NC && m_g[p] != t[p]; n++) begin
                press(B_UP);
                m_g[p] = (m_g[p] == NC) ? 1 : m_g[p] + 1;
            end
        end
        chk("set_guess_vec", guess_vec, m_pk());
        chk("set_guess_cursor", blink_led, m_cur);
    endtask

    // Scoreboard: every offered guess must match the queued expectation; transfers feed the history model.
    always @(negedge clk) begin
        if (!rst && submit_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: submit_valid=1, expected 0");
            end else begin
                chk("submit_guess", submit_guess, sb_q[0]);
                if (submit_ready) m_hist.push_back(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_valid;
        int idx;

        tbl[0]  = '{B_UP,    pk(1,1,1,2), 0};
        tbl[1]  = '{B_UP,    pk(1,1,1,3), 0};
        tbl[2]  = '{B_UP,    pk(1,1,1,4), 0};
        tbl[3]  = '{B_UP,    pk(1,1,1,5), 0};
        tbl[4]  = '{B_UP,    pk(1,1,1,6), 0};
        tbl[5]  = '{B_UP,    pk(1,1,1,1), 0};
        tbl[6]  = '{B_DOWN,  pk(1,1,1,6), 0};
        tbl[7]  = '{B_LEFT,  pk(1,1,1,6), 3};
        tbl[8]  = '{B_UP,    pk(2,1,1,6), 3};
        tbl[9]  = '{B_RIGHT, pk(2,1,1,6), 0};
        tbl[10] = '{B_RIGHT, pk(2,1,1,6), 1};
        tbl[11] = '{5'b00110, pk(2,1,6,6), 1};
        tbl[12] = '{5'b00011, pk(2,1,6,6), 0};
        tbl[13] = '{5'b01101, pk(2,1,6,1), 0};
        tbl[14] = '{B_NONE,  pk(2,1,6,1), 0};

        // Reset and idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rst_guess", guess_vec, pk(1,1,1,1));
        chk("rst_blink_en", blink_enable, 1);
        chk("rst_blink_led", blink_led, 0);
        chk("rst_valid", submit_valid, 0);
        chk("rst_hist_count", hist_count, 0);
        chk("rst_history", hist_vec, 0);
        chk("rst_hist_full", hist_full, 0);

        // Edit vectors
        for (int i = 0; i < 15; i++) begin
            press(tbl[i].btn);
            chk($sformatf("edit%0d_guess", i), guess_vec, tbl[i].exp_g);
            chk($sformatf("edit%0d_cursor", i), blink_led, tbl[i].exp_c);
        end
        m_g[0] = 1; m_g[1] = 6; m_g[2] = 1; m_g[3] = 2; m_cur = 0;

        // Reset in the middle of a handshake
        set_guess(4, 4, 4, 4);
        sb_q.push_back(m_pk());
        submit_ready = 1'b0;
        press(B_SUB);
        chk("mid_valid_a", submit_valid, 1);
        tick();
        chk("mid_valid_b", submit_valid, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", submit_valid, 0);
        sb_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_g[i] = 1;
        m_cur = 0;
        tick(); tick();
        chk("mid_rst_count", hist_count, 0);
        chk("mid_rst_history", hist_vec, 0);
        chk("mid_rst_guess", guess_vec, pk(1,1,1,1));

        // 3-1-4-2 with five stalled cycles
        set_guess(3, 1, 4, 2);
        sb_q.push_back(m_pk());
        submit_ready = 1'b0;
        press(B_SUB);
        chk("sub_blink_off", blink_enable, 0);
        n_valid = 0;
        repeat (5) begin
            if (submit_valid) n_valid++;
            tick();
        end
        submit_ready = 1'b1;
        if (submit_valid) n_valid++;
        tick();
        submit_ready = 1'b0;
        after_xfer();
        chk("stall_valid_cycles", n_valid, 6);
        chk("stall_valid_drop", submit_valid, 0);
        chk("stall_count", hist_count, 1);
        tick();
        chk("stall_history", hist_vec, 12'b010_100_001_011);
        chk("stall_guess_after", guess_vec, m_pk());

        // Submit wins over up; buttons ignored in SUBMIT; optional clear
        set_guess(5, 5, 5, 5);
        press(B_LEFT);
        m_cur = 2;
        chk("c2_cursor", blink_led, 2);
        sb_q.push_back(m_pk());
        press(5'b11000);
        chk("prio_valid", submit_valid, 1);
        chk("prio_guess", guess_vec, pk(5,5,5,5));
        press(B_UP);
        chk("sub_up_ignored", guess_vec, pk(5,5,5,5));
        press(B_LEFT);
        chk("sub_left_ignored", blink_led, 2);
        press(B_SUB);
        chk("sub_sub_valid", submit_valid, 1);
        submit_ready = 1'b1;
        tick();
        submit_ready = 1'b0;
        after_xfer();
        chk("x2_valid_drop", submit_valid, 0);
        chk("x2_count", hist_count, 2);
`ifdef GUESS_CLEAR_EN
        chk("clear_guess", guess_vec, pk(1,1,1,1));
        chk("clear_cursor", blink_led, 0);
`else
        chk("keep_guess", guess_vec, pk(5,5,5,5));
        chk("keep_cursor", blink_led, 2);
`endif

        // Fill the bank with single-cycle transfers
        for (int k = 2; k < 8; k++) begin
            set_guess(((k - 2) % 6) + 1, 6 - ((k - 2) % 6), 2, 3);
            sb_q.push_back(m_pk());
            submit_ready = 1'b1;
            press(B_SUB);
            chk("fill_valid", submit_valid, 1);
            tick();
            submit_ready = 1'b0;
            after_xfer();
            chk("fill_valid_drop", submit_valid, 0);
            chk("fill_count", hist_count, k + 1);
            chk("fill_full", hist_full, (k + 1 == HD) ? 1 : 0);
        end

        // Ninth submit is ignored
        submit_ready = 1'b1;
        press(B_SUB);
        chk("full_sub_valid", submit_valid, 0);
        tick();
        submit_ready = 1'b0;
        chk("full_count", hist_count, 8);
        chk("full_blink", blink_enable, 1);
        chk("hist_model_size", m_hist.size(), 8);

        // Browse
        hist_mode = 1'b1;
        tick();
        chk("browse_blink_off", blink_enable, 0);
        tick();
        chk("browse_newest", hist_vec, m_hist[7]);
        idx = 7;
        for (int n = 0; n < 8; n++) begin
            press(B_UP);
            idx = (idx > 0) ? idx - 1 : 0;
            tick();
            chk($sformatf("browse_up%0d", n), hist_vec, m_hist[idx]);
        end
        press(B_RIGHT);
        press(B_SUB);
        chk("browse_sub_ignored", submit_valid, 0);
        tick();
        chk("browse_hold_oldest", hist_vec, m_hist[0]);
        for (int n = 1; n <= 2; n++) begin
            press(B_DOWN);
            tick();
            chk($sformatf("browse_down%0d", n), hist_vec, m_hist[n]);
        end
        hist_mode = 1'b0;
        tick();
        chk("exit_blink_on", blink_enable, 1);
        tick();
        chk("exit_history_newest", hist_vec, m_hist[7]);

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
